// File: rtl/fifo_spram_pkg.sv
// Shared definitions for the single-port-RAM FIFO scheduler: default
// geometry, the packed core instruction layout, FSM states and the
// outstanding-read tracker slot.
package fifo_spram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;

  // Core instruction layout for the default width: {WE, RE, DI}.
  localparam int INST_WE_BIT = DATA_WIDTH + 1;
  localparam int INST_RE_BIT = DATA_WIDTH;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // One stage of the outstanding-read pipeline. A discarded read belongs
  // to a flush drain and must never surface on the response stream.
  typedef struct packed {
    logic pending;
    logic discard;
  } trk_slot_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The priority pointer moves only when
// both requesters compete, so an uncontended requester never steals the
// other's turn. Requester A wins the first conflict after reset.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_b_q;
  logic prio_b_d;
  logic conflict;

  // Grant selection and pointer advance; the loser of a conflict is
  // favoured at the next one.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    conflict = req_a & req_b;
    gnt_a    = req_a & (~req_b | ~prio_b_q);
    gnt_b    = req_b & (~req_a |  prio_b_q);
    prio_b_d = prio_b_q;
    if (conflict) begin
      prio_b_d = ~prio_b_q;
    end
  end

  // Pointer register.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/fifo_spram_sched.sv
// Issue scheduler for the single-port-RAM FIFO core. Push and pop
// requesters share one core access per cycle; occupancy is committed at
// issue time, pop data returns as a response stream three cycles after
// the grant, and a flush pulse drains the FIFO with discarded reads.
module fifo_spram_sched #(
  parameter int ADDR_WIDTH = fifo_spram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fifo_spram_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic                  flush,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH+1:0] core_inst,
  input  logic [DATA_WIDTH-1:0] core_do,
  input  logic                  core_read_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  proto_err
);

  import fifo_spram_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  // Control bits keep their offset above the data field when the data
  // width is overridden.
  localparam int WE_BIT = DATA_WIDTH + (INST_WE_BIT - fifo_spram_pkg::DATA_WIDTH);
  localparam int RE_BIT = DATA_WIDTH + (INST_RE_BIT - fifo_spram_pkg::DATA_WIDTH);

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH:0]   count_q,     count_d;
  logic [DATA_WIDTH+1:0] inst_q,      inst_d;
  trk_slot_t             slot0_q,     slot0_d;
  trk_slot_t             slot1_q,     slot1_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  proto_err_q, proto_err_d;

  logic full_int;
  logic empty_int;
  logic run_ok;
  logic wr_elig;
  logic rd_elig;
  logic wr_gnt;
  logic rd_gnt;
  logic flush_gnt;
  logic pop_issue;

  // Occupancy flags and request eligibility; nothing is granted during
  // reset or while a drain owns the core.
  always_comb begin
    full_int  = (count_q == DEPTH_CNT);
    empty_int = (count_q == '0);
    run_ok    = (state_q == RUN) && !rst;
    wr_elig   = run_ok && wr_valid && !full_int;
    rd_elig   = run_ok && rd_valid && !empty_int;
    flush_gnt = (state_q == FLUSH) && !rst && !empty_int;
    pop_issue = rd_gnt | flush_gnt;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (wr_elig),
    .req_b (rd_elig),
    .gnt_a (wr_gnt),
    .gnt_b (rd_gnt)
  );

  // Next state: a flush pulse in RUN starts a drain; the drain ends once
  // the FIFO is empty and the last discarded read is returning.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (empty_int && !(slot0_q.pending && slot0_q.discard)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Committed occupancy: at most one grant per cycle, so it never moves
  // in both directions at once.
  always_comb begin
    count_d = count_q;
    if (wr_gnt) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_issue) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Core instruction for the next cycle; the data field stays zero unless
  // this is a write.
  always_comb begin
    inst_d         = '0;
    inst_d[WE_BIT] = wr_gnt;
    inst_d[RE_BIT] = pop_issue;
    if (wr_gnt) begin
      inst_d[DATA_WIDTH-1:0] = wr_data;
    end
  end

  // Outstanding-read tracker and response path. Slot 1 lines up with the
  // cycle in which the core returns data for a read issued two cycles ago.
  always_comb begin
    slot0_d.pending = pop_issue;
    slot0_d.discard = flush_gnt;
    slot1_d         = slot0_q;
    rsp_valid_d     = core_read_valid && slot1_q.pending && !slot1_q.discard;
    rsp_data_d      = rsp_data_q;
    if (rsp_valid_d) begin
      rsp_data_d = core_do;
    end
    proto_err_d = proto_err_q | (core_read_valid && !slot1_q.pending);
  end

  // State registers; reset abandons every in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      count_q     <= '0;
      inst_q      <= '0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      inst_q      <= inst_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign wr_ready  = wr_gnt;
  assign rd_ready  = rd_gnt;
  assign core_inst = inst_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign full      = full_int;
  assign empty     = empty_int;
  assign busy      = (state_q == FLUSH);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fifo_spram_sched.sv
// Directed bench for fifo_spram_sched with a behavioural SPRAM FIFO core.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_fifo_spram_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic       rd_ready;
  logic       flush;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [9:0] core_inst;
  logic [7:0] core_do;
  logic       core_read_valid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       busy;
  logic       proto_err;

  int n_total = 0;
  int n_pass  = 0;

  logic       inject_rv = 1'b0;
  logic [7:0] mem_q[$];
  logic       m_we, m_re, m_rst;
  logic [7:0] m_di;

  fifo_spram_sched dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .flush           (flush),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .core_inst       (core_inst),
    .core_do         (core_do),
    .core_read_valid (core_read_valid),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // Core model: the instruction seen during cycle N+1 is executed and read
  // data is presented during N+2. Reset clears the storage.
  initial begin
    core_read_valid = 1'b0;
    core_do         = '0;
    forever begin
      @(negedge clk);
      m_we  = core_inst[9];
      m_re  = core_inst[8];
      m_di  = core_inst[7:0];
      m_rst = rst;
      @(posedge clk);
      #1;
      core_read_valid = 1'b0;
      if (m_rst) begin
        mem_q.delete();
      end else begin
        if (m_we) mem_q.push_back(m_di);
        if (m_re && mem_q.size() > 0) begin
          core_do         = mem_q.pop_front();
          core_read_valid = 1'b1;
        end
      end
      if (inject_rv) core_read_valid = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; flush = 1'b0; wr_data = 8'hFF;
    repeat (2) @(posedge clk);
    mid();
    n_total++; if (core_inst !== 10'h000) $display("FAIL rst_core_inst got %h exp 000", core_inst); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data got %h exp 00", rsp_data); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags got empty=%b full=%b exp 1/0", empty, full); else n_pass++;
    n_total++; if (busy !== 1'b0 || proto_err !== 1'b0) $display("FAIL rst_busy_err got %b/%b exp 0/0", busy, proto_err); else n_pass++;
    n_total++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) $display("FAIL rst_ready got %b/%b exp 0/0", wr_ready, rd_ready); else n_pass++;
    tick();
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    tick(); wr_valid = 1'b1; wr_data = 8'hA5;
    mid();
    n_total++; if (wr_ready !== 1'b1) $display("FAIL pp_wr_ready got %b exp 1", wr_ready); else n_pass++;
    tick(); wr_valid = 1'b0;
    mid();
    n_total++; if (core_inst !== 10'h2A5) $display("FAIL pp_inst_wr got %h exp 2a5", core_inst); else n_pass++;
    n_total++; if (count !== 4'd1 || empty !== 1'b0) $display("FAIL pp_count1 got %0d empty=%b exp 1/0", count, empty); else n_pass++;
    tick(); rd_valid = 1'b1;
    mid();
    n_total++; if (rd_ready !== 1'b1) $display("FAIL pp_rd_ready got %b exp 1", rd_ready); else n_pass++;
    n_total++; if (core_inst !== 10'h000) $display("FAIL pp_inst_idle got %h exp 000", core_inst); else n_pass++;
    tick(); rd_valid = 1'b0;
    mid();
    n_total++; if (core_inst !== 10'h100) $display("FAIL pp_inst_rd got %h exp 100", core_inst); else n_pass++;
    n_total++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL pp_count0 got %0d empty=%b exp 0/1", count, empty); else n_pass++;
    tick(); mid();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL pp_rsp_early got %b exp 0", rsp_valid); else n_pass++;
    tick(); mid();
    n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) $display("FAIL pp_rsp got v=%b d=%h exp 1/a5", rsp_valid, rsp_data); else n_pass++;
    tick(); mid();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL pp_rsp_late got %b exp 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_full_empty();
    tick(); rd_valid = 1'b1;
    mid();
    n_total++; if (rd_ready !== 1'b0) $display("FAIL fe_pop_empty got %b exp 0", rd_ready); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick(); rd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h10 + 8'(i);
      mid();
      n_total++; if (wr_ready !== 1'b1) $display("FAIL fe_push%0d got %b exp 1", i, wr_ready); else n_pass++;
    end
    tick(); wr_data = 8'h18;
    mid();
    n_total++; if (full !== 1'b1 || count !== 4'd8) $display("FAIL fe_full got full=%b count=%0d exp 1/8", full, count); else n_pass++;
    n_total++; if (wr_ready !== 1'b0) $display("FAIL fe_push9 got %b exp 0", wr_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(); wr_valid = 1'b0; rd_valid = 1'b1;
      mid();
      n_total++; if (rd_ready !== 1'b1) $display("FAIL fe_pop%0d got %b exp 1", i, rd_ready); else n_pass++;
    end
    tick(); rd_valid = 1'b0;
    mid();
    n_total++; if (count !== 4'd4 || full !== 1'b0) $display("FAIL fe_count4 got %0d full=%b exp 4/0", count, full); else n_pass++;
  endtask

  task automatic test_contention();
    logic exp_w;
    for (int i = 0; i < 8; i++) begin
      tick(); wr_valid = 1'b1; rd_valid = 1'b1; wr_data = 8'h40 + 8'(i);
      mid();
      exp_w = (i % 2 == 0);
      n_total++; if (wr_ready !== exp_w || rd_ready !== !exp_w) $display("FAIL ct_grant%0d got w=%b r=%b exp w=%b", i, wr_ready, rd_ready, exp_w); else n_pass++;
      n_total++; if (count !== 4'(4 + (i % 2))) $display("FAIL ct_count%0d got %0d exp %0d", i, count, 4 + (i % 2)); else n_pass++;
    end
    tick(); wr_valid = 1'b0; rd_valid = 1'b0;
    mid();
    n_total++; if (count !== 4'd4) $display("FAIL ct_count_end got %0d exp 4", count); else n_pass++;
  endtask

  task automatic test_flush();
    int busy_n, re_n, other_n, rsp_n;
    busy_n = 0; re_n = 0; other_n = 0; rsp_n = 0;
    tick(); wr_valid = 1'b1; wr_data = 8'h55;
    mid();
    tick(); wr_valid = 1'b0; flush = 1'b1;
    mid();
    n_total++; if (busy !== 1'b0 || count !== 4'd5) $display("FAIL fl_start got busy=%b count=%0d exp 0/5", busy, count); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      tick(); flush = 1'b0; wr_valid = (c == 1);
      mid();
      if (c == 0) begin
        n_total++; if (busy !== 1'b1) $display("FAIL fl_busy_rise got %b exp 1", busy); else n_pass++;
      end
      if (c == 1) begin
        n_total++; if (wr_ready !== 1'b0) $display("FAIL fl_wr_blocked got %b exp 0", wr_ready); else n_pass++;
      end
      if (busy) busy_n++;
      if (core_inst == 10'h100) re_n++;
      else if (core_inst != 10'h000) other_n++;
      if (rsp_valid) rsp_n++;
    end
    wr_valid = 1'b0;
    n_total++; if (busy_n != 7) $display("FAIL fl_busy_cycles got %0d exp 7", busy_n); else n_pass++;
    n_total++; if (re_n != 5 || other_n != 0) $display("FAIL fl_inst got re=%0d other=%0d exp 5/0", re_n, other_n); else n_pass++;
    n_total++; if (rsp_n != 0) $display("FAIL fl_rsp got %0d exp 0", rsp_n); else n_pass++;
    n_total++; if (count !== 4'd0 || empty !== 1'b1 || busy !== 1'b0) $display("FAIL fl_end got count=%0d empty=%b busy=%b exp 0/1/0", count, empty, busy); else n_pass++;
  endtask

  task automatic test_proto_err();
    #1 inject_rv = 1'b1;
    @(negedge clk);
    n_total++; if (proto_err !== 1'b0) $display("FAIL pe_before got %b exp 0", proto_err); else n_pass++;
    #1 inject_rv = 1'b0;
    @(negedge clk);
    n_total++; if (proto_err !== 1'b1) $display("FAIL pe_set got %b exp 1", proto_err); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (proto_err !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL pe_hold got err=%b rsp=%b exp 1/0", proto_err, rsp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rsp_n;
    rsp_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); wr_valid = 1'b1; wr_data = 8'h60 + 8'(i);
      mid();
    end
    tick(); wr_valid = 1'b0; rd_valid = 1'b1;
    mid();
    n_total++; if (rd_ready !== 1'b1 || count !== 4'd4) $display("FAIL rm_pop got rdy=%b count=%0d exp 1/4", rd_ready, count); else n_pass++;
    tick(); rd_valid = 1'b0; rst = 1'b1;
    mid();
    n_total++; if (count !== 4'd3 || core_inst !== 10'h100) $display("FAIL rm_inflight got count=%0d inst=%h exp 3/100", count, core_inst); else n_pass++;
    tick(); rst = 1'b0;
    mid();
    n_total++; if (core_inst !== 10'h000 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) $display("FAIL rm_rsp_inst got inst=%h v=%b d=%h exp 000/0/00", core_inst, rsp_valid, rsp_data); else n_pass++;
    n_total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL rm_count got %0d empty=%b full=%b exp 0/1/0", count, empty, full); else n_pass++;
    n_total++; if (busy !== 1'b0 || proto_err !== 1'b0) $display("FAIL rm_busy_err got %b/%b exp 0/0", busy, proto_err); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      tick(); mid();
      if (rsp_valid) rsp_n++;
    end
    n_total++; if (rsp_n != 0 || proto_err !== 1'b0) $display("FAIL rm_no_stale got rsp=%0d err=%b exp 0/0", rsp_n, proto_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full_empty();
    test_contention();
    test_flush();
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
